convert_422_ctrl: RTL

CONVERT_422_CTRL -- requirements
Module: convert_422_ctrl

---
 rtl/convert_422_ctrl_pkg.sv | 25 ++
 rtl/convert_422_ctrl_edge_detect.sv | 46 ++++
 rtl/convert_422_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/convert_422_ctrl_pkg.sv
// convert_422_ctrl shared types.
// FSM states, parameter defaults and the registered-timing bundle.
package convert_422_ctrl_pkg;

  localparam int CNT_W_DEF       = 12;
  localparam int LOCK_FRAMES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_MEASURE,
    ST_CHECK,
    ST_LOCKED
  } state_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic vs_rise;
    logic de_rise;
    logic de_fall;
  } sync_t;

endpackage

// File: rtl/convert_422_ctrl_edge_detect.sv
// First pipeline stage: registers raw timing.
// Edges are taken on the registered copies.
module video_edge_detect
  import convert_422_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hsync_in,
  input  logic  vsync_in,
  input  logic  de_in,
  output sync_t sync
);

  logic hs_q;
  logic vs_q;
  logic de_q;
  logic vs_p;
  logic de_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      vs_p <= 1'b0;
      de_p <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      de_q <= de_in;
      vs_p <= vs_q;
      de_p <= de_q;
    end
  end

  always_comb begin
    sync         = '0;
    sync.hs      = hs_q;
    sync.vs      = vs_q;
    sync.de      = de_q;
    sync.vs_rise = vs_q & ~vs_p;
    sync.de_rise = de_q & ~de_p;
    sync.de_fall = ~de_q & de_p;
  end

endmodule

// File: rtl/convert_422_ctrl.sv
// Timing lock controller for the 4:4:4-to-4:2:2 path.
// Measures geometry, locks after stable frames, 2-cycle latency.
module convert_422_ctrl
  import convert_422_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  input  logic             clr_err_in,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out,
  output logic             pair_phase_out,
  output logic             line_start_out,
  output logic             frame_start_out,
  output logic [CNT_W-1:0] active_width_out,
  output logic [CNT_W-1:0] active_height_out,
  output logic             locked_out,
  output logic             odd_width_out,
  output logic             timing_err_out
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  sync_t s;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] pix_q, pix_n;
  logic [CNT_W-1:0] line_q, line_n;
  logic [CNT_W-1:0] ref_w_q, ref_w_n;
  logic [CNT_W-1:0] cap_w_q, cap_w_n;
  logic [CNT_W-1:0] cap_h_q, cap_h_n;
  logic [MW-1:0]    match_q, match_n;
  logic             ref_ok_q, ref_ok_n;
  logic             arm_q, arm_n;
  logic             fp_q, fp_n;
  logic             ph_q, ph_n;
  logic             clr_q;

  logic [CNT_W-1:0] hgt;
  logic             sat_pix;
  logic             sat_line;
  logic             w_bad;
  logic             h_bad;
  logic             err_set;
  logic             err_n;
  logic             lock_n;
  logic             lock_entry;
  logic             fs;

  video_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .sync     (s)
  );

  always_comb begin
    state_n  = state_q;
    pix_n    = pix_q;
    line_n   = line_q;
    ref_w_n  = ref_w_q;
    ref_ok_n = ref_ok_q;
    arm_n    = arm_q;
    cap_w_n  = cap_w_q;
    cap_h_n  = cap_h_q;
    match_n  = match_q;
    err_set  = 1'b0;

    sat_pix  = s.de & ~s.de_rise & (pix_q == CMAX);
    sat_line = s.de_rise & ~s.vs_rise & (line_q == CMAX);
    // a line still active at the boundary moves to the new frame
    hgt      = line_q - CNT_W'(s.de & ~s.de_rise);
    w_bad    = s.de_fall & (pix_q != cap_w_q);
    h_bad    = s.vs_rise & (hgt != cap_h_q);

    if (s.de_rise)
      pix_n = CNT_W'(1);
    else if (s.de && !sat_pix)
      pix_n = pix_q + CNT_W'(1);

    if (s.vs_rise)
      line_n = CNT_W'(s.de);
    else if (s.de_rise && !sat_line)
      line_n = line_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (enable_in)
          state_n = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (s.vs_rise) begin
          state_n  = ST_MEASURE;
          arm_n    = 1'b1;
          ref_ok_n = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (s.de_fall && arm_q && !ref_ok_q) begin
          ref_w_n  = pix_q;
          ref_ok_n = 1'b1;
        end
        if (s.vs_rise) begin
          if (arm_q && ref_ok_q) begin
            cap_w_n = ref_w_q;
            cap_h_n = hgt;
            match_n = MW'(1);
            state_n = (LOCK_FRAMES <= 1) ? ST_LOCKED : ST_CHECK;
          end else begin
            arm_n    = 1'b1;
            ref_ok_n = 1'b0;
          end
        end
      end
      ST_CHECK: begin
        if (w_bad || h_bad) begin
          state_n  = ST_MEASURE;
          match_n  = '0;
          arm_n    = s.vs_rise;
          ref_ok_n = 1'b0;
        end else if (s.vs_rise) begin
          match_n = match_q + MW'(1);
          if (int'(match_q) + 1 >= LOCK_FRAMES)
            state_n = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_bad || h_bad) begin
          state_n  = ST_MEASURE;
          match_n  = '0;
          arm_n    = s.vs_rise;
          ref_ok_n = 1'b0;
          err_set  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if ((sat_pix || sat_line) && state_q != ST_IDLE) begin
      state_n  = ST_MEASURE;
      match_n  = '0;
      arm_n    = 1'b0;
      ref_ok_n = 1'b0;
      err_set  = 1'b1;
    end

    if (!enable_in)
      state_n = ST_IDLE;
  end

  // new errors take priority over a same-cycle clear
  assign err_n      = err_set | (~clr_q & timing_err_out);
  assign lock_n     = (state_n == ST_LOCKED);
  assign lock_entry = lock_n & (state_q != ST_LOCKED);
  assign ph_n       = s.de & ~s.de_rise & ~ph_q;
  assign fs         = s.de_rise & (fp_q | s.vs_rise);
  assign fp_n       = s.vs_rise ? ~s.de_rise : (fp_q & ~s.de_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pix_q    <= '0;
      line_q   <= '0;
      ref_w_q  <= '0;
      ref_ok_q <= 1'b0;
      arm_q    <= 1'b0;
      cap_w_q  <= '0;
      cap_h_q  <= '0;
      match_q  <= '0;
      fp_q     <= 1'b0;
      ph_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      pix_q    <= pix_n;
      line_q   <= line_n;
      ref_w_q  <= ref_w_n;
      ref_ok_q <= ref_ok_n;
      arm_q    <= arm_n;
      cap_w_q  <= cap_w_n;
      cap_h_q  <= cap_h_n;
      match_q  <= match_n;
      fp_q     <= fp_n;
      ph_q     <= ph_n;
      clr_q    <= clr_err_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_out         <= 1'b0;
      vsync_out         <= 1'b0;
      de_out            <= 1'b0;
      pair_phase_out    <= 1'b0;
      line_start_out    <= 1'b0;
      frame_start_out   <= 1'b0;
      active_width_out  <= '0;
      active_height_out <= '0;
      locked_out        <= 1'b0;
      odd_width_out     <= 1'b0;
      timing_err_out    <= 1'b0;
    end else begin
      hsync_out       <= s.hs;
      vsync_out       <= s.vs;
      de_out          <= s.de & lock_n;
      pair_phase_out  <= ph_n & lock_n;
      line_start_out  <= s.de_rise & lock_n;
      frame_start_out <= fs & lock_n;
      locked_out      <= lock_n;
      timing_err_out  <= err_n;
      if (lock_entry) begin
        active_width_out  <= cap_w_n;
        active_height_out <= cap_h_n;
        odd_width_out     <= cap_w_n[0];
      end
    end
  end

endmodule
